// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared types and constants for the serial (UART) SFR blocks.
//             Provides the receiver FSM state encoding, the byte width and
//             the default bit period used by both SerialIn and SerialOut.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : serial_rx_fifo
//  Purpose  : Small receive FIFO for serial_in. Head is presented
//             combinationally; reads as zero when empty.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             push, wr_data - write strobe and byte
//             pop           - discard head (ignored when empty)
//             rd_data       - head byte, 0 when empty
//             count         - entries held, 0..DEPTH
//             full, empty   - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO can still
    // accept a simultaneous push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule : serial_rx_fifo
`default_nettype wire

// File: rtl/serial_in.sv
`default_nettype none
// ============================================================================
//  Module   : serial_in
//  Purpose  : 8N1 UART receiver for the SFR block. Synchronises uart_rx,
//             validates start/stop bits and queues bytes in a small FIFO
//             that the CPU reads and pops.
//  Ports    : clk, rst   - clock, asynchronous active-high reset
//             uart_rx    - serial line, idle high, asynchronous
//             rd_pop     - 1-cycle strobe: discard FIFO head
//             clr_err    - 1-cycle strobe: clear overrun and frame_err
//             rx_data    - FIFO head byte, 8'h00 when empty
//             rx_count   - bytes held, 0..FIFO_DEPTH
//             rx_empty   - rx_count == 0
//             overrun    - sticky: byte dropped because FIFO was full
//             frame_err  - sticky: stop bit sampled low
//  Revision : 1.0 - initial release
// ============================================================================
module serial_in
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_pop,
    input  logic                          clr_err,
    output logic [DATA_W-1:0]             rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_empty,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_BIT_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Input synchroniser. Preset to the idle level so reset never looks
    // like a start bit. sync_fill marks when rxs truly reflects the pin.
    // ------------------------------------------------------------------
    logic       sync_meta;
    logic       rxs;
    logic [1:0] sync_fill;
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            sync_meta <= uart_rx;
            rxs       <= sync_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    rx_state_t          state;
    rx_state_t          state_next;

    // A start is accepted only after the real line has been seen high in
    // IDLE, so a reset in the middle of a frame cannot resync onto a data
    // bit that happens to be low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (state == IDLE && rxs && sync_fill[1]) begin
            armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and bit timer
    // ------------------------------------------------------------------
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_next;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  shreg_next;
    logic               push_byte;
    logic               frame_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer + TIMER_W'(1);
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        push_byte    = 1'b0;
        frame_set    = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (armed && !rxs) begin
                    state_next = START;
                end
            end

            START: begin
                if (timer == HALF_BIT_LAST) begin
                    timer_next = '0;
                    if (rxs) begin
                        state_next = IDLE;      // glitch, not a real start
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end

            DATA: begin
                if (timer == FULL_BIT_LAST) begin
                    timer_next = '0;
                    shreg_next = {rxs, shreg[DATA_W-1:1]};  // LSB first
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end

            STOP: begin
                if (timer == FULL_BIT_LAST) begin
                    timer_next = '0;
                    if (rxs) begin
                        push_byte  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                timer_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                timer_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic fifo_full;

    serial_rx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_byte),
        .wr_data (shreg),
        .pop     (rd_pop),
        .rd_data (rx_data),
        .count   (rx_count),
        .full    (fifo_full),
        .empty   (rx_empty)
    );

    // ------------------------------------------------------------------
    // Sticky status flags; a new event wins over a coincident clear.
    // ------------------------------------------------------------------
    logic overrun_set;

    assign overrun_set = push_byte & fifo_full & ~rd_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule : serial_in
`default_nettype wire

// File: tb/tb_serial_in.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_in
//  Purpose  : Self-checking bench for serial_in. Expected bytes are queued
//             as frames are sent and compared as the FIFO head is read.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_in;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Edge (counted from the start-bit edge) on which the stop bit is
    // sampled and the byte pushed: 2 sync + 1 IDLE + half bit + 9 bits.
    localparam int PUSH_EDGE = 3 + CPB / 2 + 9 * CPB;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     uart_rx;
    logic                     rd_pop;
    logic                     clr_err;
    logic [7:0]               rx_data;
    logic [$clog2(DEPTH):0]   rx_count;
    logic                     rx_empty;
    logic                     overrun;
    logic                     frame_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] exp_q [$];
    logic       exp_ovr;

    always #5 clk = ~clk;

    serial_in #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rd_pop    (rd_pop),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_count  (rx_count),
        .rx_empty  (rx_empty),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one full frame; returns on the edge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = d[i];
            repeat (CPB) @(posedge clk);
        end
        #1 uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                      exp_ovr = 1'b1;
        send_frame(d, 1'b1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        @(posedge clk); #1;
        e = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check(tag, rx_data, e);
        rd_pop = 1'b1;
        @(posedge clk); #1 rd_pop = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; uart_rx = 1'b1; rd_pop = 1'b0; clr_err = 1'b0; exp_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  rx_data,   0);
        check("rst_count", rx_count,  0);
        check("rst_empty", rx_empty,  1);
        check("rst_ovr",   overrun,   0);
        check("rst_ferr",  frame_err, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // 1: single byte
        send_byte(8'hA5);
        check("t1_data",  rx_data,   8'hA5);
        check("t1_count", rx_count,  exp_q.size());
        check("t1_ovr",   overrun,   0);
        check("t1_ferr",  frame_err, 0);
        pop_check("t1_pop");
        check("t1_empty", rx_empty, 1);

        // 2: overflow by one, then drain
        for (int b = 1; b <= 5; b++) send_byte(8'(b));
        check("t2_count", rx_count, exp_q.size());
        check("t2_head",  rx_data,  8'h01);
        check("t2_ovr",   overrun,  exp_ovr);
        for (int k = 0; k < 4; k++) pop_check("t2_pop");
        check("t2_empty_data", rx_data,  0);
        check("t2_empty",      rx_empty, 1);
        pulse_clr();
        #1 check("t2_clr_ovr", overrun, 0);

        // 3: short glitch on idle line
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("t3_count", rx_count,  0);
        check("t3_ferr",  frame_err, 0);
        check("t3_ovr",   overrun,   0);

        // 4: framing error, long break, recovery
        send_frame(8'h3C, 1'b0);
        #1;
        check("t4_ferr",  frame_err, 1);
        check("t4_count", rx_count,  0);
        repeat (40 * CPB) @(posedge clk);
        #1;
        check("t4_break_count", rx_count, 0);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_byte(8'h55);
        check("t4_count2", rx_count, exp_q.size());
        pop_check("t4_pop");
        pulse_clr();
        #1 check("t4_clr_ferr", frame_err, 0);

        // 5: full FIFO, pop on the push cycle
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b));
        check("t5_full", rx_count, 4);
        fork
            send_frame(8'h14, 1'b1);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1;
                check("t5_head", rx_data, exp_q[0]);
                rd_pop = 1'b1;
                @(posedge clk); #1 rd_pop = 1'b0;
                void'(exp_q.pop_front());
            end
        join
        exp_q.push_back(8'h14);
        repeat (4) @(posedge clk);
        #1;
        check("t5_count", rx_count, 4);
        check("t5_ovr",   overrun,  0);
        check("t5_head2", rx_data,  exp_q[0]);

        // clr_err coincident with a new overrun
        send_byte(8'h20);
        check("ovr_set", overrun, exp_ovr);
        fork
            send_frame(8'h21, 1'b1);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1 clr_err = 1'b1;
                @(posedge clk); #1 clr_err = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("ovr_clr_coinc", overrun,  1);
        check("ovr_count",     rx_count, 4);

        // 6: reset in the middle of a frame
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check("t6_rst_data",  rx_data,   0);
                check("t6_rst_count", rx_count,  0);
                check("t6_rst_empty", rx_empty,  1);
                check("t6_rst_ovr",   overrun,   0);
                check("t6_rst_ferr",  frame_err, 0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        #1;
        check("t6_no_partial", rx_count, 0);
        send_byte(8'h12);
        check("t6_count", rx_count, exp_q.size());
        check("t6_data",  rx_data,  8'h12);
        pop_check("t6_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_in
`default_nettype wire
